// File: rtl/av_uart_tx_slave.sv
// rtl/av_uart_tx_slave.sv - Avalon-MM UART transmitter: byte-wide TX FIFO, 8N1 serialiser, status read
module av_uart_tx_slave #(
    parameter logic [31:0] BASE_ADDR    = 32'h108,
    parameter int          CLKS_PER_BIT = 434,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] av_address,
    input  logic [31:0] av_writedata,
    input  logic        av_write_n,
    input  logic        av_read_n,
    output logic [31:0] av_readdata,
    output logic        av_waitrequest,
    output logic        uart_tx,
    output logic        tx_busy
);

    // CLKS_PER_BIT >= 2 and FIFO_DEPTH a power of two in 2..16 keep every width below >= 1
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    // ---------------------------------------------------------------
    // State
    // ---------------------------------------------------------------
    state_t              r_state;
    logic [7:0]          r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [CNT_W-1:0]    r_count;
    logic [7:0]          r_shift;
    logic [2:0]          r_bit;
    logic [BAUD_W-1:0]   r_baud;
    logic                r_tx;

    // ---------------------------------------------------------------
    // Combinational nets
    // ---------------------------------------------------------------
    state_t              w_state_next;
    logic                w_sel;
    logic                w_wr_req;
    logic                w_rd_req;
    logic                w_full;
    logic                w_empty;
    logic                w_active;
    logic                w_bit_end;
    logic                w_pop;
    logic                w_push;
    logic [7:0]          w_head;
    logic [7:0]          w_shift_next;
    logic [2:0]          w_bit_next;
    logic [BAUD_W-1:0]   w_baud_next;
    logic                w_tx_next;
    logic [31:0]         w_status;
    logic                w_unused;

    // Only the low byte of a store carries data
    assign w_unused = ^av_writedata[31:8];

    // ---------------------------------------------------------------
    // Bus decode and handshake
    // ---------------------------------------------------------------
    assign w_sel    = (av_address == BASE_ADDR);
    assign w_wr_req = w_sel & ~av_write_n;
    assign w_rd_req = w_sel & ~av_read_n;

    assign w_full   = (r_count == CNT_FULL);
    assign w_empty  = (r_count == '0);
    assign w_active = (r_state != S_IDLE);
    assign w_head   = r_mem[r_rd_ptr];

    // Stall only a store that hits a full FIFO; a pop in the same cycle frees the slot
    assign av_waitrequest = ~(w_wr_req & w_full & ~w_pop);
    assign w_push         = w_wr_req & av_waitrequest;

    assign w_status    = {16'b0, 8'(r_count), 5'b0, w_active, w_empty, w_full};
    // Reset forces the read bus to zero even while a read strobe is present
    assign av_readdata = (w_rd_req & reset) ? w_status : 32'b0;

    assign uart_tx = r_tx;
    assign tx_busy = w_active | ~w_empty;

    assign w_bit_end = (r_baud == BAUD_LAST);

    // ---------------------------------------------------------------
    // TX FIFO
    // ---------------------------------------------------------------

    // Storage array: written on every accepted store, no reset needed
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= av_writedata[7:0];
        end
    end

    // Pointers wrap naturally at the power-of-two depth; count tracks occupancy
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ---------------------------------------------------------------
    // Serialiser FSM
    // ---------------------------------------------------------------

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: STOP chains straight into START when more bytes wait
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_state_next = S_START;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (w_bit_end && (r_bit == 3'd7)) begin
                    w_state_next = S_STOP;
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    w_state_next = w_empty ? S_IDLE : S_START;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Output logic: FIFO pop, next datapath values and the next line level
    always_comb begin
        w_pop        = 1'b0;
        w_shift_next = r_shift;
        w_bit_next   = r_bit;
        w_baud_next  = w_bit_end ? '0 : (r_baud + BAUD_W'(1));
        w_tx_next    = 1'b1;

        case (r_state)
            S_IDLE: begin
                w_baud_next = '0;
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_shift_next = w_head;
                end
            end
            S_START: begin
                w_bit_next = 3'd0;
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_shift_next = {1'b0, r_shift[7:1]};
                    w_bit_next   = r_bit + 3'd1;
                end
            end
            S_STOP: begin
                if (w_bit_end && !w_empty) begin
                    w_pop        = 1'b1;
                    w_shift_next = w_head;
                end
            end
            default: begin
                w_baud_next = '0;
            end
        endcase

        // Line level is computed from the coming state so the register presents it on entry
        case (w_state_next)
            S_IDLE:  w_tx_next = 1'b1;
            S_START: w_tx_next = 1'b0;
            S_DATA:  w_tx_next = w_shift_next[0];
            S_STOP:  w_tx_next = 1'b1;
            default: w_tx_next = 1'b1;
        endcase
    end

    // Datapath registers: shift register, bit and baud counters, glitch-free line driver
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_shift <= 8'h00;
            r_bit   <= 3'd0;
            r_baud  <= '0;
            r_tx    <= 1'b1;
        end else begin
            r_shift <= w_shift_next;
            r_bit   <= w_bit_next;
            r_baud  <= w_baud_next;
            r_tx    <= w_tx_next;
        end
    end

endmodule

// File: tb/tb_av_uart_tx_slave.sv
// tb/tb_av_uart_tx_slave.sv - scoreboard bench for av_uart_tx_slave
module tb_av_uart_tx_slave;

    localparam int          CPB   = 4;
    localparam int          FRAME = 10 * CPB;
    localparam logic [31:0] BASE  = 32'h108;

    logic        clock        = 1'b0;
    logic        reset        = 1'b0;
    logic [31:0] av_address   = 32'h0;
    logic [31:0] av_writedata = 32'h0;
    logic        av_write_n   = 1'b1;
    logic        av_read_n    = 1'b1;
    logic [31:0] av_readdata;
    logic        av_waitrequest;
    logic        uart_tx;
    logic        tx_busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [7:0] exp_q[$];
    int         starts[$];

    av_uart_tx_slave #(
        .BASE_ADDR    (BASE),
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (4)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .av_address     (av_address),
        .av_writedata   (av_writedata),
        .av_write_n     (av_write_n),
        .av_read_n      (av_read_n),
        .av_readdata    (av_readdata),
        .av_waitrequest (av_waitrequest),
        .uart_tx        (uart_tx),
        .tx_busy        (tx_busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int last_start();
        if (starts.size() == 0) return -1;
        return starts[starts.size()-1];
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Store: hold the strobe until an edge accepts it; acc = accepting edge number
    task automatic wr(input logic [31:0] a, input logic [31:0] d, output int acc, output int stalls);
        logic w;
        int   e;
        stalls = 0;
        acc    = -1;
        av_address   = a;
        av_writedata = d;
        av_write_n   = 1'b0;
        for (int k = 0; k < 200; k++) begin
            #1;
            w = av_waitrequest;
            e = cyc + 1;
            @(posedge clock);
            if (w) begin
                acc = e;
                break;
            end
            stalls++;
            @(negedge clock);
        end
        @(negedge clock);
        av_write_n   = 1'b1;
        av_address   = 32'h0;
        av_writedata = 32'h0;
        chk("wr_accepted", acc >= 0, 1'b1);
        if (acc >= 0 && a == BASE) exp_q.push_back(d[7:0]);
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        av_address = a;
        av_read_n  = 1'b0;
        #1 d = av_readdata;
        #1;
        av_read_n  = 1'b1;
        av_address = 32'h0;
        @(negedge clock);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 5000) begin
            @(negedge clock);
            t++;
        end
        idle(2);
        chk("drain_all_sent", exp_q.size(), 0);
    endtask

    // Serial monitor: decodes each 8N1 frame from line samples and scores it
    int         m_s;
    logic [7:0] m_b;
    bit         m_ok;
    bit         m_ab;
    int         m_k;
    logic [7:0] m_exp;

    initial begin : monitor
        forever begin
            @(negedge clock);
            if (!reset) begin
                exp_q.delete();
            end else if (uart_tx === 1'b0) begin
                m_s  = cyc;
                starts.push_back(m_s);
                m_ok = 1'b1;
                m_ab = 1'b0;
                m_b  = 8'h00;
                for (int j = 0; j < FRAME; j++) begin
                    if (j > 0) @(negedge clock);
                    if (!reset) begin
                        m_ab = 1'b1;
                        exp_q.delete();
                        break;
                    end
                    if (j < CPB) begin
                        if (uart_tx !== 1'b0) m_ok = 1'b0;
                    end else if (j >= 9 * CPB) begin
                        if (uart_tx !== 1'b1) m_ok = 1'b0;
                    end else begin
                        m_k = (j - CPB) / CPB;
                        if (((j - CPB) % CPB) == 0) m_b[m_k] = uart_tx;
                        else if (uart_tx !== m_b[m_k]) m_ok = 1'b0;
                    end
                end
                if (!m_ab) begin
                    chk("frame_shape", m_ok, 1'b1);
                    if (exp_q.size() == 0) begin
                        chk("frame_expected", 32'h0, 32'h1);
                    end else begin
                        m_exp = exp_q.pop_front();
                        chk("frame_byte", m_b, m_exp);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: cycle %0d reached, required completion before it", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int          acc, st, s0, acc6, base_i, t, s, n;
        logic [31:0] d;

        // Reset held with random bus activity
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            av_address   = ($urandom_range(0, 1) == 1) ? BASE : 32'($urandom);
            av_writedata = $urandom;
            av_write_n   = 1'($urandom);
            av_read_n    = (i % 2 == 0) ? 1'b0 : 1'($urandom);
            #1;
            chk("rst_uart_tx", uart_tx, 1'b1);
            chk("rst_waitrequest", av_waitrequest, 1'b1);
            chk("rst_readdata", av_readdata, 32'h0);
            chk("rst_tx_busy", tx_busy, 1'b0);
        end
        @(negedge clock);
        av_address = 32'h0; av_writedata = 32'h0; av_write_n = 1'b1; av_read_n = 1'b1;
        #3 reset = 1'b1;
        @(negedge clock);
        rd(BASE, d);
        chk("status_after_reset", d, 32'h0000_0002);

        // Single byte timing
        wr(BASE, 32'hFFFF_FF55, acc, st);
        chk("single_no_stall", st, 0);
        t = 0;
        while (tx_busy !== 1'b0 && t < 200) begin
            @(negedge clock);
            t++;
        end
        chk("single_busy_fall", cyc, acc + FRAME + 1);
        chk("single_start_edge", last_start(), acc + 1);

        // Fill, status, stall and back-to-back frames
        idle(3);
        base_i = starts.size();
        wr(BASE, 32'h01, s0, st);  chk("fill1_no_stall", st, 0);
        wr(BASE, 32'h02, acc, st); chk("fill2_no_stall", st, 0);
        wr(BASE, 32'h03, acc, st); chk("fill3_no_stall", st, 0);
        wr(BASE, 32'h04, acc, st); chk("fill4_no_stall", st, 0);
        rd(BASE, d);
        chk("status_three_queued", d, 32'h0000_0304);
        wr(BASE, 32'h05, acc, st); chk("fill5_no_stall", st, 0);
        wr(BASE, 32'h06, acc6, st);
        chk("stall_release_edge", acc6, s0 + 1 + FRAME);
        drain();
        chk("b2b_frame_count", starts.size() - base_i, 6);
        if (starts.size() >= base_i + 6) begin
            chk("fill_first_start", starts[base_i], s0 + 1);
            for (int i = 0; i < 5; i++)
                chk("b2b_gap", starts[base_i+i+1] - starts[base_i+i], FRAME);
        end

        // Address filter
        idle(4);
        wr(32'h104, 32'hAA, acc, st);
        rd(32'h10C, d);
        chk("rd_other_addr", d, 32'h0);
        rd(BASE, d);
        chk("status_after_filter", d, 32'h0000_0002);
        n = 0;
        repeat (60) begin
            @(negedge clock);
            if (uart_tx !== 1'b1) n++;
        end
        chk("filter_line_idle", n, 0);

        // Reset during DATA bit 3
        wr(BASE, 32'hC3, acc, st);
        s = acc + 1;
        wr(BASE, 32'h11, acc, st);
        wr(BASE, 32'h22, acc, st);
        t = 0;
        while (cyc < s + 17 && t < 200) begin
            @(negedge clock);
            t++;
        end
        chk("midrst_bit3_level", uart_tx, 1'b0);
        #3 reset = 1'b0;
        #1;
        chk("midrst_uart_tx", uart_tx, 1'b1);
        chk("midrst_tx_busy", tx_busy, 1'b0);
        chk("midrst_waitrequest", av_waitrequest, 1'b1);
        av_address = BASE;
        av_read_n  = 1'b0;
        #1 chk("midrst_readdata", av_readdata, 32'h0);
        av_read_n  = 1'b1;
        av_address = 32'h0;
        @(negedge clock);
        @(negedge clock);
        #3 reset = 1'b1;
        @(negedge clock);
        rd(BASE, d);
        chk("midrst_fifo_empty", d, 32'h0000_0002);
        wr(BASE, 32'h0F, acc, st);
        drain();
        chk("post_reset_start", last_start(), acc + 1);

        // Randomized traffic
        for (int i = 0; i < 50; i++) begin
            case ($urandom_range(0, 5))
                0, 1, 2: wr(BASE, $urandom, acc, st);
                3:       wr(BASE + 32'(4 * $urandom_range(1, 8)), $urandom, acc, st);
                4: begin
                    rd(BASE ^ (32'h4 << $urandom_range(0, 5)), d);
                    chk("rand_rd_other", d, 32'h0);
                end
                default: idle($urandom_range(1, 60));
            endcase
        end
        drain();
        t = 0;
        while (tx_busy !== 1'b0 && t < 200) begin
            @(negedge clock);
            t++;
        end
        chk("end_tx_busy", tx_busy, 1'b0);
        chk("end_uart_tx", uart_tx, 1'b1);
        rd(BASE, d);
        chk("end_status", d, 32'h0000_0002);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
